// File: rtl/tohost_monitor.sv
// Snoops data-memory stores to the tohost word and reports pass/fail/timeout to the sim top.
// Define TOHOST_WATCHDOG_EN to enable the TIMEOUT_CYCLES watchdog; otherwise TIMEOUT is unreachable.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// S_RUN     | program running, cycles counting, waiting for a tohost report
// S_PASS    | tohost written with 1; sticky until clear
// S_FAIL    | tohost written with odd value != 1; test_num latched; sticky
// S_TIMEOUT | watchdog expired with no report; sticky until clear
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic        clear,
    output logic        halt,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [30:0] test_num,
    output logic [31:0] cycles
);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] cycles_q, cycles_nxt;
    logic [30:0] test_num_q, test_num_nxt;
    logic        done_q, done_nxt;
    logic        hit;
    logic        wd_expire;
    logic        unused_addr_lsbs;

    // Configuration sanity: watchdog needs a nonzero limit, tohost must be word aligned.
    generate
        if (TIMEOUT_CYCLES < 1 || TOHOST_ADDR[1:0] != 2'b00) begin : g_bad_cfg
            $error("tohost_monitor: invalid TIMEOUT_CYCLES or unaligned TOHOST_ADDR");
        end
    endgenerate

    assign unused_addr_lsbs = ^mem_addr[1:0];

    assign hit = mem_we && (mem_addr[31:2] == TOHOST_ADDR[31:2]) && (mem_wstrb == 4'hf);

`ifdef TOHOST_WATCHDOG_EN
    localparam logic [31:0] TC_LAST = 32'(TIMEOUT_CYCLES - 1);
    assign wd_expire = (cycles_q == TC_LAST);
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RUN;
            cycles_q   <= '0;
            test_num_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cycles_q   <= cycles_nxt;
            test_num_q <= test_num_nxt;
            done_q     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cycles_nxt   = cycles_q;
        test_num_nxt = test_num_q;
        done_nxt     = 1'b0;
        if (clear) begin
            state_nxt    = S_RUN;
            cycles_nxt   = '0;
            test_num_nxt = '0;
        end else begin
            case (state)
                S_RUN: begin
                    // A report beats watchdog expiry; even values are not reports.
                    if (hit && mem_wdata[0]) begin
                        done_nxt = 1'b1;
                        if (mem_wdata == 32'd1) begin
                            state_nxt = S_PASS;
                        end else begin
                            state_nxt    = S_FAIL;
                            test_num_nxt = mem_wdata[31:1];
                        end
                    end else if (wd_expire) begin
                        state_nxt = S_TIMEOUT;
                        done_nxt  = 1'b1;
                    end else if (cycles_q != 32'hffff_ffff) begin
                        cycles_nxt = cycles_q + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign halt     = (state != S_RUN);
    assign pass     = (state == S_PASS);
    assign fail     = (state == S_FAIL);
`ifdef TOHOST_WATCHDOG_EN
    assign timeout  = (state == S_TIMEOUT);
`else
    assign timeout  = 1'b0;
`endif
    assign done     = done_q;
    assign test_num = test_num_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed self-checking bench for tohost_monitor (TIMEOUT_CYCLES overridden to 20).
module tb_tohost_monitor;

    logic        clk;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        clear;
    logic        halt;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [30:0] test_num;
    logic [31:0] cycles;

    int n_checks = 0;
    int n_errors = 0;

    tohost_monitor #(
        .TOHOST_ADDR   (32'h0000_1000),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .clear    (clear),
        .halt     (halt),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .timeout  (timeout),
        .test_num (test_num),
        .cycles   (cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags packed as {pass, fail, timeout, halt, done}
    task automatic check_flags(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, pass, fail, timeout, halt, done}, {27'd0, exp});
    endtask

    // One clock with the given bus/clear values, then return to idle at the negedge.
    task automatic step(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, input logic clr);
        mem_we    = we;
        mem_addr  = addr;
        mem_wstrb = strb;
        mem_wdata = data;
        clear     = clr;
        @(posedge clk);
        @(negedge clk);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        clear     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        clear     = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_flags("reset_flags", 5'b00000);
        check("reset_cycles", cycles, 32'd0);
        check("reset_test_num", {1'b0, test_num}, 32'd0);
        rst = 1'b0;

        // Ten idle RUN edges, then PASS report on the next edge
        idle(10);
        check("run_cycles_10", cycles, 32'd10);
        check_flags("run_flags", 5'b00000);
        step(1'b1, 32'h1000, 4'hf, 32'h1, 1'b0);
        check_flags("pass_entry", 5'b10011);
        check("pass_cycles", cycles, 32'd10);
        check("pass_test_num", {1'b0, test_num}, 32'd0);
        step(1'b1, 32'h1000, 4'hf, 32'h7, 1'b0);
        check_flags("pass_sticky", 5'b10010);
        check("pass_cycles_hold", cycles, 32'd10);

        // Clear, then FAIL with test 3; a later pass report is ignored
        step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        check_flags("clear_flags", 5'b00000);
        check("clear_cycles", cycles, 32'd0);
        step(1'b1, 32'h1000, 4'hf, 32'h7, 1'b0);
        check_flags("fail_entry", 5'b01011);
        check("fail_test_num", {1'b0, test_num}, 32'd3);
        check("fail_cycles", cycles, 32'd0);
        step(1'b1, 32'h1000, 4'hf, 32'h1, 1'b0);
        check_flags("fail_sticky", 5'b01010);
        check("fail_test_num_hold", {1'b0, test_num}, 32'd3);

        // Clear together with a pass report: clear wins
        step(1'b1, 32'h1000, 4'hf, 32'h1, 1'b1);
        check_flags("clear_hit_flags", 5'b00000);
        check("clear_hit_cycles", cycles, 32'd0);
        check("clear_hit_test_num", {1'b0, test_num}, 32'd0);
        step(1'b1, 32'h1000, 4'hf, 32'h1, 1'b0);
        check_flags("after_clear_pass", 5'b10011);

        // Non-qualifying stores stay in RUN
        step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        step(1'b1, 32'h1000, 4'h1, 32'h1, 1'b0);
        check_flags("partial_strb", 5'b00000);
        step(1'b1, 32'h1004, 4'hf, 32'h1, 1'b0);
        check_flags("wrong_addr", 5'b00000);
        step(1'b0, 32'h1000, 4'hf, 32'h1, 1'b0);
        check_flags("we_low", 5'b00000);
        check("nonhit_cycles", cycles, 32'd3);
        step(1'b1, 32'h1000, 4'hf, 32'h2, 1'b0);
        check_flags("even_value", 5'b00000);
        step(1'b1, 32'h1000, 4'hf, 32'h1, 1'b0);
        check_flags("pass_after_ignored", 5'b10011);

        // Byte offset within the tohost word still hits
        step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        step(1'b1, 32'h1003, 4'hf, 32'h5, 1'b0);
        check_flags("offset_fail", 5'b01011);
        check("offset_test_num", {1'b0, test_num}, 32'd2);

        // Watchdog
        step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
`ifdef TOHOST_WATCHDOG_EN
        idle(19);
        check("wd_cycles_19", cycles, 32'd19);
        check_flags("wd_before", 5'b00000);
        idle(1);
        check_flags("wd_entry", 5'b00111);
        check("wd_cycles_frozen", cycles, 32'd19);
        idle(1);
        check_flags("wd_sticky", 5'b00110);
        step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        idle(19);
        step(1'b1, 32'h1000, 4'hf, 32'h1, 1'b0);
        check_flags("wd_hit_wins", 5'b10011);
        check("wd_hit_cycles", cycles, 32'd19);
`else
        idle(25);
        check_flags("nowd_no_timeout", 5'b00000);
        check("nowd_cycles", cycles, 32'd25);
        step(1'b1, 32'h1000, 4'hf, 32'h1, 1'b0);
        check_flags("nowd_pass", 5'b10011);
        check("nowd_pass_cycles", cycles, 32'd25);
`endif

        // Async reset between edges while in PASS
        #2;
        rst = 1'b1;
        #1;
        check_flags("async_rst_flags", 5'b00000);
        check("async_rst_cycles", cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tohost_monitor.md
# tohost_monitor

Host-side responder for the riscv-tests `tohost` protocol. It snoops the core's data-memory write port and captures stores to the `tohost` word. It decodes the value into pass/fail and a failing test number, and raises a halt/done indication. A watchdog flags programs that never report. It sits beside `Core` in the simulation top level and gives ISA-test benches a registered, synthesizable pass/fail source instead of a fixed tick count.

## Interface
- `TOHOST_ADDR`, 32'h0000_1000, byte address of the `tohost` word; must be word aligned.
- `TIMEOUT_CYCLES`, 5000, running cycles before the watchdog fires; must be ≥ 1.
- `clk  in  1  clock`; all state updates on the rising edge.
- `rst  in  1`: reset, asynchronous and active-high.
- `mem_we  in  1`: data-memory write enable from the core.
- `mem_addr  in  32`: data-memory byte address.
- `mem_wstrb  in  4`: byte strobes for the write.
- `mem_wdata  in  32`: write data.
- `clear  in  1`: synchronous re-arm; returns the block to RUN with the counter at 0.
- `halt  out  1`: request to stop the core; high in every terminal state.
- `done  out  1`: one-cycle pulse on entry to any terminal state.
- `pass  out  1`: level; high in PASS.
- `fail  out  1`: level; high in FAIL.
- `timeout  out  1`: level; high in TIMEOUT.
- `test_num  out  31`: failing test number (`tohost[31:1]`); 0 unless in FAIL.
- `cycles  out  32`: count of RUN cycles, frozen in terminal states.

## Operation
- States: RUN, PASS, FAIL, TIMEOUT. Reset state is RUN.
- Reset values: all outputs 0, `cycles` = 0.
- A hit is `mem_we` && `mem_addr[31:2] == TOHOST_ADDR[31:2]` && `mem_wstrb == 4'hf`. Partial-word stores to the address are ignored.
- RUN, hit, `mem_wdata == 1`: go to PASS.
- RUN, hit, `mem_wdata[0] == 1` and `mem_wdata != 1`: go to FAIL; latch `test_num = mem_wdata[31:1]`.
- RUN, hit, `mem_wdata[0] == 0` (including 0): ignored; stay in RUN.
- RUN, no qualifying hit: `cycles` += 1, saturating at 32'hffff_ffff. TIMEOUT entry is described under Configuration.
- PASS, FAIL and TIMEOUT are sticky. Further writes are ignored and `cycles` holds.
- `clear` acts in any state. Next state is RUN; `cycles`, `test_num`, `pass`, `fail`, `timeout`, `halt` and `done` all go to 0.
- `clear` and a hit in the same cycle: `clear` wins and the hit is dropped.
- Hit and watchdog expiry in the same cycle: the hit wins (PASS/FAIL).
- `rst` mid-run: outputs go to their reset values immediately and asynchronously, independent of `clk`.

## Timing
- Inputs are sampled at edge N. State, `pass`/`fail`/`test_num`/`halt` and the `done` pulse are visible after edge N, so latency is 1 cycle.
- `done` is high for exactly one cycle per terminal entry and never repeats without a `clear`.
- `cycles` after edge N equals the number of RUN edges since reset or `clear`, excluding the edge that entered a terminal state.
- No back-pressure: the monitor never stalls the memory write. `halt` is advisory to the core/bench.

## Configuration
- `TOHOST_WATCHDOG_EN` defined:
  - In RUN with no qualifying hit, when `cycles == TIMEOUT_CYCLES - 1`, the next edge enters TIMEOUT.
  - That edge sets `timeout`, `halt` and the `done` pulse. `cycles` is left at `TIMEOUT_CYCLES - 1`.
- Not defined:
  - The TIMEOUT state is unreachable and `timeout` is tied to 0.
  - `TIMEOUT_CYCLES` is unused and `cycles` counts freely with saturation.

## Test plan
- Reset, store 32'h1 full-word to 0x1000 at cycle 10 -> after that edge `pass`=1, `halt`=1, `done` pulse for 1 cycle, `cycles`=10, `test_num`=0.
- Store 32'h0000_0007 to 0x1000 -> `fail`=1, `test_num`=3; a later store of 32'h1 leaves `fail`=1 and `pass`=0.
- Store 32'h1 with `mem_wstrb`=4'h1, then a store to 0x1004, then 32'h2 to 0x1000 -> stays in RUN, all flags 0; a following 32'h1 to 0x1000 -> PASS.
- With `TOHOST_WATCHDOG_EN` and `TIMEOUT_CYCLES`=20, no stores -> `timeout`=1 and a `done` pulse after edge 20, `cycles`=19.
  - Repeat with a hit of 32'h1 on edge 20 -> PASS, no timeout.
- In FAIL, assert `clear` together with a hit of 32'h1 -> RUN, all flags 0, `cycles`=0.
  - Next cycle, a hit of 32'h1 -> PASS.
- Assert `rst` asynchronously between edges while in PASS -> `pass`, `halt` and `cycles` read 0 before the next edge.
